graph_mem_arbiter: RTL and testbench

- Shares one graph_memory read port between NUM_REQ graph_fetch requesters, e.g. one per processor lane when PROC_BITS>0.
- Each cycle, grants at most one pending request using round-robin arbitration, then issues it to memory.
- Records the winner's ID in an in-order tag FIFO and routes each returning memory word back to the requester that issued it.
- Sits between the graph_fetch mem_req/mem_valid ports and graph_memory port A or port B. Instantiate one arbiter per port.

---
 rtl/graph_mem_arbiter_pkg.sv | 11 +
 rtl/graph_mem_arbiter_if.sv | 37 +++
 rtl/graph_mem_arbiter_rr_arbiter.sv | 50 +++++
 rtl/graph_mem_arbiter.sv | 109 ++++++++++
 tb/tb_graph_mem_arbiter.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/graph_mem_arbiter_pkg.sv
// Shared defaults and requester-ID type for the graph memory arbiter slice.
package graph_pkg;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_ADDR_W  = 32;
  localparam int DEF_DATA_W  = 32;
  localparam int DEF_MAX_OUT = 4;

  typedef logic [$clog2(DEF_NUM_REQ)-1:0] req_id_t;

endpackage

// File: rtl/graph_mem_arbiter_if.sv
// Requester/memory bus of the arbiter; slave is the arbiter side, master the environment side.
interface graph_mem_arbiter_if
  import graph_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int MAX_OUT = DEF_MAX_OUT
);

  localparam int CNT_W = $clog2(MAX_OUT) + 1;

  logic [NUM_REQ-1:0]        req_valid_in;
  logic [NUM_REQ*ADDR_W-1:0] req_addr_in;
  logic [NUM_REQ-1:0]        req_ready_out;
  logic [DATA_W-1:0]         resp_data_out;
  logic [NUM_REQ-1:0]        resp_valid_out;
  logic [ADDR_W-1:0]         mem_req_out;
  logic                      mem_valid_out;
  logic [DATA_W-1:0]         mem_data_in;
  logic                      mem_valid_in;
  logic [CNT_W-1:0]          outstanding_out;
  logic                      err_out;

  modport slave (
    input  req_valid_in, req_addr_in, mem_data_in, mem_valid_in,
    output req_ready_out, resp_data_out, resp_valid_out,
           mem_req_out, mem_valid_out, outstanding_out, err_out
  );

  modport master (
    output req_valid_in, req_addr_in, mem_data_in, mem_valid_in,
    input  req_ready_out, resp_data_out, resp_valid_out,
           mem_req_out, mem_valid_out, outstanding_out, err_out
  );

endinterface

// File: rtl/graph_mem_arbiter_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant searched from r_ptr, pointer
// advances past the winner on every grant.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic [N-1:0]         i_req,
  input  logic                 i_en,
  output logic [N-1:0]         o_grant,
  output logic [$clog2(N)-1:0] o_grant_id,
  output logic                 o_granted
);

  localparam int ID_W = $clog2(N);

  logic [ID_W-1:0] r_ptr;
  logic [ID_W-1:0] w_idx [N];
  logic [N-1:0]    w_hit;

  // w_hit[k] is the request k places after the pointer; N is a power of two so the add wraps
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_rot
      assign w_idx[gi] = r_ptr + ID_W'(gi);
      assign w_hit[gi] = i_req[w_idx[gi]];
    end
  endgenerate

  always_comb begin
    o_granted  = 1'b0;
    o_grant_id = '0;
    o_grant    = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (i_en && w_hit[k]) begin
        o_granted  = 1'b1;
        o_grant_id = w_idx[k];
      end
    end
    if (o_granted) o_grant[o_grant_id] = 1'b1;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_ptr <= '0;
    end else if (o_granted) begin
      r_ptr <= o_grant_id + ID_W'(1);
    end
  end

endmodule

// File: rtl/graph_mem_arbiter.sv
// Shares one memory read port between NUM_REQ requesters; an in-order tag FIFO
// routes each returning word back to the requester that issued the read.
module graph_mem_arbiter
  import graph_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int MAX_OUT = DEF_MAX_OUT
) (
  input  logic               clk_in,
  input  logic               rst_in,
  graph_mem_arbiter_if.slave bus
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int PTR_W = $clog2(MAX_OUT);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0]  w_addr [NUM_REQ];
  logic [NUM_REQ-1:0] w_grant;
  logic [ID_W-1:0]    w_grant_id;
  logic               w_granted;
  logic               w_enable;
  logic               w_empty;
  logic               w_pop;
  logic [ID_W-1:0]    w_head_tag;
  logic [NUM_REQ-1:0] w_head_onehot;

  logic [ID_W-1:0]    r_tag_mem [MAX_OUT];
  logic [CNT_W-1:0]   r_wr_ptr;
  logic [CNT_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;
  logic [ADDR_W-1:0]  r_mem_req;
  logic               r_mem_valid;
  logic [NUM_REQ-1:0] r_resp_valid;
  logic [DATA_W-1:0]  r_resp_data;
  logic               r_err;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_addr
      assign w_addr[gi] = bus.req_addr_in[gi*ADDR_W +: ADDR_W];
    end
  endgenerate

  // Gating with rst_in keeps the combinational grant at zero while reset is held
  assign w_enable = rst_in && (r_count < CNT_W'(MAX_OUT));

  rr_arbiter #(
    .N (NUM_REQ)
  ) u_rr_arbiter (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .i_req      (bus.req_valid_in),
    .i_en       (w_enable),
    .o_grant    (w_grant),
    .o_grant_id (w_grant_id),
    .o_granted  (w_granted)
  );

  // Extra wrap bit on the pointers: equal pointers mean empty, never full
  assign w_empty       = (r_wr_ptr == r_rd_ptr);
  assign w_pop         = bus.mem_valid_in && !w_empty;
  assign w_head_tag    = r_tag_mem[r_rd_ptr[PTR_W-1:0]];
  assign w_head_onehot = NUM_REQ'(1) << w_head_tag;

  always_ff @(posedge clk_in) begin
    if (w_granted) r_tag_mem[r_wr_ptr[PTR_W-1:0]] <= w_grant_id;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_mem_req    <= '0;
      r_mem_valid  <= 1'b0;
      r_resp_valid <= '0;
      r_resp_data  <= '0;
      r_err        <= 1'b0;
    end else begin
      r_mem_valid  <= w_granted;
      r_resp_valid <= w_pop ? w_head_onehot : '0;
      if (w_granted) begin
        r_mem_req <= w_addr[w_grant_id];
        r_wr_ptr  <= r_wr_ptr + CNT_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr    <= r_rd_ptr + CNT_W'(1);
        r_resp_data <= bus.mem_data_in;
      end
      case ({w_granted, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      if (bus.mem_valid_in && w_empty) r_err <= 1'b1;
    end
  end

  assign bus.req_ready_out   = w_grant;
  assign bus.mem_req_out     = r_mem_req;
  assign bus.mem_valid_out   = r_mem_valid;
  assign bus.resp_valid_out  = r_resp_valid;
  assign bus.resp_data_out   = r_resp_data;
  assign bus.outstanding_out = r_count;
  assign bus.err_out         = r_err;

endmodule

// File: tb/tb_graph_mem_arbiter.sv
// Bench for graph_mem_arbiter: per-cycle vector table plus directed multi-cycle
// sequences, with a 2-cycle in-order memory model answering data = addr ^ 0xDEAD0000.
module tb_graph_mem_arbiter;
  import graph_pkg::*;

  localparam int NR = DEF_NUM_REQ;
  localparam int AW = DEF_ADDR_W;
  localparam int DW = DEF_DATA_W;
  localparam int MO = DEF_MAX_OUT;

  localparam logic [127:0] A_ONE  = {32'h0, 32'h10, 32'h0, 32'h0};
  localparam logic [127:0] A_FAIR = {32'd4, 32'd3, 32'd2, 32'd1};

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  graph_mem_arbiter_if #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .MAX_OUT(MO)) bus ();

  graph_mem_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .MAX_OUT(MO)) dut (
    .clk_in (clk),
    .rst_in (rst_n),
    .bus    (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Memory model: responses queued on mem_valid_out, released two cycles later in order
  typedef struct {
    logic [31:0] data;
    int          rdy;
  } mrsp_t;
  mrsp_t mq[$];
  int    cyc        = 0;
  bit    mem_hold   = 1'b0;
  int    mem_credit = 0;
  bit    spur       = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      mq.delete();
      bus.mem_valid_in = 1'b0;
      bus.mem_data_in  = '0;
    end else begin
      if (bus.mem_valid_out) mq.push_back('{data: bus.mem_req_out ^ 32'hDEAD0000, rdy: cyc + 2});
      if (spur) begin
        bus.mem_valid_in = 1'b1;
        bus.mem_data_in  = 32'h0BAD0BAD;
      end else if (mq.size() > 0 && mq[0].rdy <= cyc && (!mem_hold || mem_credit > 0)) begin
        bus.mem_valid_in = 1'b1;
        bus.mem_data_in  = mq[0].data;
        void'(mq.pop_front());
        if (mem_hold) mem_credit--;
      end else begin
        bus.mem_valid_in = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [3:0] rdy, input logic mv,
                         input logic [31:0] mreq, input logic [3:0] rv,
                         input logic [31:0] rdata, input logic [2:0] outst, input logic err);
    chk({tag, ".ready"}, 32'(bus.req_ready_out), 32'(rdy));
    chk({tag, ".mem_valid"}, 32'(bus.mem_valid_out), 32'(mv));
    chk({tag, ".mem_req"}, bus.mem_req_out, mreq);
    chk({tag, ".resp_valid"}, 32'(bus.resp_valid_out), 32'(rv));
    chk({tag, ".resp_data"}, bus.resp_data_out, rdata);
    chk({tag, ".outstanding"}, 32'(bus.outstanding_out), 32'(outst));
    chk({tag, ".err"}, 32'(bus.err_out), 32'(err));
  endtask

  typedef struct {
    logic [3:0]   valid;
    logic [127:0] addr;
    logic [3:0]   ready;
    logic         mv;
    logic [31:0]  mreq;
    logic [3:0]   rv;
    logic [31:0]  rdata;
    logic [2:0]   outst;
  } vec_t;
  vec_t vt[18];

  logic [3:0]  exp_rv [4];
  logic [31:0] exp_rd [4];

  initial begin
    // Single request from requester 2, then all four continuously (pointer starts at 3)
    vt[0]  = '{4'b0100, A_ONE,  4'b0100, 1'b0, 32'h0,  4'b0000, 32'h0,        3'd0};
    vt[1]  = '{4'b0000, A_ONE,  4'b0000, 1'b1, 32'h10, 4'b0000, 32'h0,        3'd1};
    vt[2]  = '{4'b0000, A_ONE,  4'b0000, 1'b0, 32'h10, 4'b0000, 32'h0,        3'd1};
    vt[3]  = '{4'b0000, A_ONE,  4'b0000, 1'b0, 32'h10, 4'b0000, 32'h0,        3'd1};
    vt[4]  = '{4'b0000, A_ONE,  4'b0000, 1'b0, 32'h10, 4'b0100, 32'hDEAD0010, 3'd0};
    vt[5]  = '{4'b1111, A_FAIR, 4'b1000, 1'b0, 32'h10, 4'b0000, 32'hDEAD0010, 3'd0};
    vt[6]  = '{4'b1111, A_FAIR, 4'b0001, 1'b1, 32'h4,  4'b0000, 32'hDEAD0010, 3'd1};
    vt[7]  = '{4'b1111, A_FAIR, 4'b0010, 1'b1, 32'h1,  4'b0000, 32'hDEAD0010, 3'd2};
    vt[8]  = '{4'b1111, A_FAIR, 4'b0100, 1'b1, 32'h2,  4'b0000, 32'hDEAD0010, 3'd3};
    vt[9]  = '{4'b1111, A_FAIR, 4'b1000, 1'b1, 32'h3,  4'b1000, 32'hDEAD0004, 3'd3};
    vt[10] = '{4'b1111, A_FAIR, 4'b0001, 1'b1, 32'h4,  4'b0001, 32'hDEAD0001, 3'd3};
    vt[11] = '{4'b1111, A_FAIR, 4'b0010, 1'b1, 32'h1,  4'b0010, 32'hDEAD0002, 3'd3};
    vt[12] = '{4'b1111, A_FAIR, 4'b0100, 1'b1, 32'h2,  4'b0100, 32'hDEAD0003, 3'd3};
    vt[13] = '{4'b0000, A_FAIR, 4'b0000, 1'b1, 32'h3,  4'b1000, 32'hDEAD0004, 3'd3};
    vt[14] = '{4'b0000, A_FAIR, 4'b0000, 1'b0, 32'h3,  4'b0001, 32'hDEAD0001, 3'd2};
    vt[15] = '{4'b0000, A_FAIR, 4'b0000, 1'b0, 32'h3,  4'b0010, 32'hDEAD0002, 3'd1};
    vt[16] = '{4'b0000, A_FAIR, 4'b0000, 1'b0, 32'h3,  4'b0100, 32'hDEAD0003, 3'd0};
    vt[17] = '{4'b0000, A_FAIR, 4'b0000, 1'b0, 32'h3,  4'b0000, 32'hDEAD0003, 3'd0};

    bus.req_valid_in = '0;
    bus.req_addr_in  = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    chk_all("reset", 4'b0, 1'b0, 32'h0, 4'b0, 32'h0, 3'd0, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 18; i++) begin
      tick();
      bus.req_valid_in = vt[i].valid;
      bus.req_addr_in  = vt[i].addr;
      sample();
      chk_all($sformatf("vec%0d", i), vt[i].ready, vt[i].mv, vt[i].mreq,
              vt[i].rv, vt[i].rdata, vt[i].outst, 1'b0);
      $display("vec%0d: valid=%b ready=%b mem_valid=%b mem_req=%h resp_valid=%b resp_data=%h out=%0d",
               i, vt[i].valid, bus.req_ready_out, bus.mem_valid_out, bus.mem_req_out,
               bus.resp_valid_out, bus.resp_data_out, bus.outstanding_out);
    end

    // Backpressure: memory stalled, four grants fill the tag FIFO
    begin
      logic [3:0] bp_rdy [6];
      logic [2:0] bp_out [6];
      bp_rdy = '{4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b0000, 4'b0000};
      bp_out = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
      for (int b = 0; b < 6; b++) begin
        tick();
        mem_hold = 1'b1;
        bus.req_valid_in = 4'b1111;
        bus.req_addr_in  = A_FAIR;
        sample();
        chk($sformatf("bp%0d.ready", b), 32'(bus.req_ready_out), 32'(bp_rdy[b]));
        chk($sformatf("bp%0d.outstanding", b), 32'(bus.outstanding_out), 32'(bp_out[b]));
        $display("bp%0d: ready=%b out=%0d", b, bus.req_ready_out, bus.outstanding_out);
      end
    end
    tick();
    mem_credit = 1;
    sample();
    chk("bp_pop.ready", 32'(bus.req_ready_out), 32'h0);
    chk("bp_pop.outstanding", 32'(bus.outstanding_out), 32'd4);
    tick();
    sample();
    chk("bp_regrant.ready", 32'(bus.req_ready_out), 32'b1000);
    chk("bp_regrant.outstanding", 32'(bus.outstanding_out), 32'd3);
    chk("bp_regrant.resp_valid", 32'(bus.resp_valid_out), 32'b1000);
    chk("bp_regrant.resp_data", bus.resp_data_out, 32'hDEAD0004);
    $display("bp_regrant: ready=%b resp_valid=%b resp_data=%h", bus.req_ready_out,
             bus.resp_valid_out, bus.resp_data_out);
    tick();
    bus.req_valid_in = '0;
    mem_hold = 1'b0;
    sample();
    exp_rv = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    exp_rd = '{32'hDEAD0001, 32'hDEAD0002, 32'hDEAD0003, 32'hDEAD0004};
    begin
      int got = 0;
      for (int k = 0; k < 20 && got < 4; k++) begin
        if (bus.resp_valid_out != 0) begin
          chk($sformatf("drain%0d.resp_valid", got), 32'(bus.resp_valid_out), 32'(exp_rv[got]));
          chk($sformatf("drain%0d.resp_data", got), bus.resp_data_out, exp_rd[got]);
          $display("drain%0d: resp_valid=%b resp_data=%h", got, bus.resp_valid_out, bus.resp_data_out);
          got++;
        end
        if (got < 4) begin
          tick();
          sample();
        end
      end
      chk("drain.count", 32'(got), 32'd4);
      chk("drain.outstanding", 32'(bus.outstanding_out), 32'd0);
    end

    // Spurious response with nothing outstanding
    tick();
    spur = 1'b1;
    sample();
    chk("spur.err_before", 32'(bus.err_out), 32'd0);
    tick();
    spur = 1'b0;
    sample();
    chk("spur.err", 32'(bus.err_out), 32'd1);
    chk("spur.resp_valid", 32'(bus.resp_valid_out), 32'd0);
    chk("spur.outstanding", 32'(bus.outstanding_out), 32'd0);
    repeat (2) begin
      tick();
      sample();
    end
    chk("spur.err_sticky", 32'(bus.err_out), 32'd1);
    chk("spur.resp_valid_later", 32'(bus.resp_valid_out), 32'd0);
    $display("spur: err=%b resp_valid=%b", bus.err_out, bus.resp_valid_out);

    // Three reads in flight, then asynchronous reset mid-cycle
    tick();
    mem_hold = 1'b1;
    bus.req_valid_in = 4'b0111;
    bus.req_addr_in  = A_FAIR;
    sample();
    chk("rst_g0.ready", 32'(bus.req_ready_out), 32'b0001);
    tick();
    bus.req_valid_in = 4'b0110;
    sample();
    chk("rst_g1.ready", 32'(bus.req_ready_out), 32'b0010);
    tick();
    bus.req_valid_in = 4'b0100;
    sample();
    chk("rst_g2.ready", 32'(bus.req_ready_out), 32'b0100);
    tick();
    bus.req_valid_in = 4'b0000;
    sample();
    chk("rst_pre.outstanding", 32'(bus.outstanding_out), 32'd3);
    tick();
    bus.req_valid_in = 4'b1010;
    rst_n = 1'b0;
    #1;
    chk_all("rst_async", 4'b0, 1'b0, 32'h0, 4'b0, 32'h0, 3'd0, 1'b0);
    sample();
    chk("rst_held.ready", 32'(bus.req_ready_out), 32'd0);
    tick();
    rst_n = 1'b1;
    mem_hold = 1'b0;
    #1;
    chk("rst_rel.ready", 32'(bus.req_ready_out), 32'b0010);
    $display("rst_rel: ready=%b out=%0d", bus.req_ready_out, bus.outstanding_out);
    sample();
    tick();
    bus.req_valid_in = 4'b1000;
    sample();
    chk_all("rst_x1", 4'b1000, 1'b1, 32'h2, 4'b0, 32'h0, 3'd1, 1'b0);
    tick();
    bus.req_valid_in = 4'b0000;
    sample();
    chk_all("rst_x2", 4'b0000, 1'b1, 32'h4, 4'b0, 32'h0, 3'd2, 1'b0);
    tick();
    sample();
    chk("rst_x3.resp_valid", 32'(bus.resp_valid_out), 32'd0);
    tick();
    sample();
    chk("rst_x4.resp_valid", 32'(bus.resp_valid_out), 32'b0010);
    chk("rst_x4.resp_data", bus.resp_data_out, 32'hDEAD0002);
    tick();
    sample();
    chk("rst_x5.resp_valid", 32'(bus.resp_valid_out), 32'b1000);
    chk("rst_x5.resp_data", bus.resp_data_out, 32'hDEAD0004);
    chk("rst_x5.err", 32'(bus.err_out), 32'd0);
    tick();
    sample();
    chk("rst_x6.outstanding", 32'(bus.outstanding_out), 32'd0);
    chk("rst_x6.resp_valid", 32'(bus.resp_valid_out), 32'd0);
    $display("rst_x6: out=%0d err=%b", bus.outstanding_out, bus.err_out);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected bench completion");
    $fatal(1, "watchdog expired");
  end

endmodule
